// File: rtl/misr_bist_compactor.sv
// Multiple-input signature register with a compaction controller.
// Compacts an NIN-bit response bus into a WIDTH-bit signature over a
// programmed number of cycles and compares the result with a golden value.
module misr_bist_compactor #(
  parameter int unsigned             WIDTH = 16,
  parameter int unsigned             NIN   = 3,
  parameter logic [WIDTH-1:0]        POLY  = 16'h002D,
  parameter logic [WIDTH-1:0]        SEED  = '0,
  parameter int unsigned             CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             start,
  input  logic             abort,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic [CNT_W-1:0] num_cycles,
  input  logic [WIDTH-1:0] golden,
  input  logic [NIN-1:0]   din,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] signature
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sig_q,   sig_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [WIDTH-1:0] gold_q,  gold_d;
  logic             pass_q,  pass_d;

  logic [WIDTH-1:0] din_ext;
  logic [WIDTH-1:0] sig_next;
  logic [WIDTH-1:0] start_sig;

  // Zero-extend the response bus so din[k] lands in stage k.
  always_comb begin
    din_ext          = '0;
    din_ext[NIN-1:0] = din;
  end

  // One MISR step: shift, fold back the feedback taps, mix in the responses.
  always_comb begin
    sig_next = {sig_q[WIDTH-2:0], 1'b0}
             ^ (sig_q[WIDTH-1] ? POLY : '0)
             ^ din_ext;
  end

  // Signature at the start of a run: a simultaneous seed load wins.
  always_comb begin
    start_sig = seed_load ? seed_in : sig_q;
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    gold_d  = gold_q;
    pass_d  = pass_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          gold_d = golden;
          cnt_d  = num_cycles;
          sig_d  = start_sig;
          pass_d = 1'b0;
          if (num_cycles == '0) begin
            state_d = DONE;
            pass_d  = (start_sig == golden);
          end else begin
            state_d = RUN;
          end
        end else if (seed_load) begin
          sig_d = seed_in;
          if (state_q == DONE) begin
            pass_d = (seed_in == gold_q);
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          pass_d  = 1'b0;
        end else begin
          sig_d = sig_next;
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end
          // Count of 0 is unreachable in RUN; treat it as terminal so the
          // counter can never wrap.
          if (cnt_q <= CNT_W'(1)) begin
            state_d = DONE;
            pass_d  = (sig_next == gold_q);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      sig_q   <= SEED;
      cnt_q   <= '0;
      gold_q  <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      gold_q  <= gold_d;
      pass_q  <= pass_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign pass      = pass_q;
  assign signature = sig_q;

endmodule

// File: tb/tb_misr_bist_compactor.sv
// Self-checking bench for misr_bist_compactor: a small 4-bit instance for
// the detailed sequences and random runs, plus a default 16-bit instance.
module tb_misr_bist_compactor;

  logic CLK = 1'b0;
  logic RST_N;

  // 4-bit instance signals
  logic        a_start, a_abort, a_seed_load;
  logic [3:0]  a_seed_in, a_golden, a_sig;
  logic [15:0] a_num;
  logic [1:0]  a_din;
  logic        a_busy, a_done, a_pass;

  // default 16-bit instance signals
  logic        b_start, b_abort, b_seed_load;
  logic [15:0] b_seed_in, b_golden, b_sig, b_num;
  logic [2:0]  b_din;
  logic        b_busy, b_done, b_pass;

  int nvec  = 0;
  int nfail = 0;

  always #5 CLK = ~CLK;

  misr_bist_compactor #(.WIDTH(4), .NIN(2), .POLY(4'h3), .SEED(4'h0), .CNT_W(16)) dut_a (
    .CLK(CLK), .RST_N(RST_N), .start(a_start), .abort(a_abort),
    .seed_load(a_seed_load), .seed_in(a_seed_in), .num_cycles(a_num),
    .golden(a_golden), .din(a_din), .busy(a_busy), .done(a_done),
    .pass(a_pass), .signature(a_sig)
  );

  misr_bist_compactor dut_b (
    .CLK(CLK), .RST_N(RST_N), .start(b_start), .abort(b_abort),
    .seed_load(b_seed_load), .seed_in(b_seed_in), .num_cycles(b_num),
    .golden(b_golden), .din(b_din), .busy(b_busy), .done(b_done),
    .pass(b_pass), .signature(b_sig)
  );

  typedef struct {
    logic [3:0] seed;
    int         n;
    logic [1:0] d;
    logic [3:0] gold;
    logic [3:0] exp_sig;
    logic       exp_pass;
  } vec_t;

  // Reference: multiply the signature polynomial by x modulo the full
  // characteristic polynomial (x^w + taps), then add the response word.
  function automatic logic [31:0] mstep(input int w, input logic [31:0] p,
                                        input logic [31:0] s, input logic [31:0] d);
    logic [32:0] t;
    t = {1'b0, s} << 1;
    if (t[w]) t = t ^ ((33'd1 << w) | {1'b0, p});
    return t[31:0] ^ d;
  endfunction

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic a_state(input string tag, input logic [3:0] s, input logic bz,
                         input logic dn, input logic ps);
    chk({tag, ".sig"},  32'(a_sig),  32'(s));
    chk({tag, ".busy"}, 32'(a_busy), 32'(bz));
    chk({tag, ".done"}, 32'(a_done), 32'(dn));
    chk({tag, ".pass"}, 32'(a_pass), 32'(ps));
  endtask

  // Seed, start, hold din constant for n cycles, check the final state.
  task automatic a_run_vec(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    a_seed_load = 1'b1; a_seed_in = v.seed;
    tick;
    a_seed_load = 1'b0;
    a_start = 1'b1; a_num = 16'(v.n); a_golden = v.gold; a_din = v.d;
    tick;
    a_start = 1'b0; a_golden = ~v.gold; a_num = 16'hFFFF;
    repeat (v.n) tick;
    a_state(tag, v.exp_sig, 1'b0, 1'b1, v.exp_pass);
  endtask

  initial begin
    vec_t        vt [5];
    logic [3:0]  es, seed, gold;
    logic [1:0]  dins [32];
    logic [3:0]  pred;
    logic [15:0] bs, bd;
    int          n, abort_at, mode;
    logic [3:0]  seq [4];

    vt[0] = '{4'h1, 4,  2'b00, 4'h3, 4'h3, 1'b1};
    vt[1] = '{4'h0, 3,  2'b01, 4'h7, 4'h7, 1'b1};
    vt[2] = '{4'h0, 3,  2'b01, 4'h6, 4'h7, 1'b0};
    vt[3] = '{4'h1, 15, 2'b00, 4'h1, 4'h1, 1'b1};
    vt[4] = '{4'h5, 0,  2'b11, 4'h5, 4'h5, 1'b1};

    RST_N = 1'b0;
    a_start = 0; a_abort = 0; a_seed_load = 0; a_seed_in = 4'hA;
    a_golden = 0; a_num = 0; a_din = 2'b11;
    b_start = 0; b_abort = 0; b_seed_load = 0; b_seed_in = '0;
    b_golden = 0; b_num = 0; b_din = 0;
    tick; tick;
    a_state("reset", 4'h0, 1'b0, 1'b0, 1'b0);
    chk("reset16.sig", 32'(b_sig), 32'h0);
    chk("reset16.done", 32'(b_done), 32'h0);
    RST_N = 1'b1;
    tick;
    chk("idle_din_ignored", 32'(a_sig), 32'h0);

    // seed 1, din 0, 4 cycles: 2,4,8,3 then pass
    seq = '{4'h2, 4'h4, 4'h8, 4'h3};
    a_seed_load = 1; a_seed_in = 4'h1; a_din = 0;
    tick;
    a_seed_load = 0;
    chk("seed_load", 32'(a_sig), 32'h1);
    a_start = 1; a_num = 4; a_golden = 4'h3;
    tick;
    a_start = 0;
    a_state("start4", 4'h1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick;
      a_state($sformatf("seq4_%0d", i), seq[i], i != 3, i == 3, i == 3);
    end
    tick;
    a_state("done_hold", 4'h3, 1'b0, 1'b1, 1'b1);

    for (int i = 0; i < 5; i++) a_run_vec(vt[i], i);

    // abort after two updates of a 4-cycle run
    a_seed_load = 1; a_seed_in = 4'h1; a_din = 0;
    tick;
    a_seed_load = 0; a_start = 1; a_num = 4; a_golden = 4'h3;
    tick;
    a_start = 0;
    tick; tick;
    chk("pre_abort.sig", 32'(a_sig), 32'h4);
    a_abort = 1; a_din = 2'b11;
    tick;
    a_abort = 0;
    a_state("abort", 4'h4, 1'b0, 1'b0, 1'b0);
    tick;
    a_state("abort_idle", 4'h4, 1'b0, 1'b0, 1'b0);
    a_run_vec(vt[1], 10);

    // start+seed_load together with zero cycles
    a_seed_load = 1; a_seed_in = 4'h9; a_start = 1; a_num = 0; a_golden = 4'h9;
    tick;
    a_seed_load = 0; a_start = 0;
    a_state("zero_seed", 4'h9, 1'b0, 1'b1, 1'b1);

    // start/seed_load while busy are ignored
    a_seed_load = 1; a_seed_in = 4'h0; a_start = 1; a_num = 3; a_golden = 4'h7; a_din = 2'b01;
    tick;
    a_seed_load = 0; a_start = 0;
    tick;
    a_start = 1; a_num = 10; a_golden = 4'h0; a_seed_load = 1; a_seed_in = 4'hF;
    tick;
    a_start = 0; a_seed_load = 0;
    chk("busy_ignore.sig", 32'(a_sig), 32'h3);
    tick;
    a_state("busy_ignore", 4'h7, 1'b0, 1'b1, 1'b1);

    // seed_load in DONE recomputes pass against the held golden
    a_seed_load = 1; a_seed_in = 4'h2;
    tick;
    a_state("done_seed_miss", 4'h2, 1'b0, 1'b1, 1'b0);
    a_seed_in = 4'h7;
    tick;
    a_seed_load = 0;
    a_state("done_seed_hit", 4'h7, 1'b0, 1'b1, 1'b1);

    // reset mid-run
    a_start = 1; a_num = 5; a_din = 2'b10;
    tick;
    a_start = 0;
    tick; tick;
    RST_N = 0;
    tick;
    RST_N = 1;
    a_state("mid_reset", 4'h0, 1'b0, 1'b0, 1'b0);

    // randomized runs against the reference model
    es = 4'h0;
    a_seed_load = 1; a_seed_in = 4'h0;
    tick;
    a_seed_load = 0;
    for (int r = 0; r < 40; r++) begin
      n = $urandom_range(0, 12);
      seed = 4'($urandom);
      mode = $urandom_range(0, 2);
      for (int k = 0; k < 32; k++) dins[k] = 2'($urandom);
      abort_at = (n > 0 && ($urandom % 4) == 0) ? $urandom_range(0, n - 1) : -1;
      if (mode == 0) begin
        a_seed_load = 1; a_seed_in = seed;
        tick;
        a_seed_load = 0;
        es = seed;
        chk("rnd.seed", 32'(a_sig), 32'(es));
      end
      pred = (mode == 1) ? seed : es;
      for (int k = 0; k < n; k++) pred = 4'(mstep(4, 32'h3, 32'(pred), 32'(dins[k])));
      gold = ($urandom % 2) ? pred : 4'($urandom);
      a_start = 1; a_num = 16'(n); a_golden = gold;
      a_seed_load = (mode == 1); a_seed_in = seed; a_din = 2'($urandom);
      tick;
      a_start = 0; a_seed_load = 0; a_golden = 4'($urandom); a_num = 16'($urandom);
      if (mode == 1) es = seed;
      chk("rnd.start_sig", 32'(a_sig), 32'(es));
      chk("rnd.start_busy", 32'(a_busy), 32'(n != 0));
      for (int k = 0; k < n; k++) begin
        if (k == abort_at) begin
          a_abort = 1; a_din = dins[k];
          tick;
          a_abort = 0;
          a_state("rnd.abort", es, 1'b0, 1'b0, 1'b0);
          break;
        end
        a_din = dins[k];
        tick;
        es = 4'(mstep(4, 32'h3, 32'(es), 32'(dins[k])));
        chk("rnd.sig", 32'(a_sig), 32'(es));
        chk("rnd.busy", 32'(a_busy), 32'(k < n - 1));
      end
      if (abort_at < 0) begin
        chk("rnd.done", 32'(a_done), 32'h1);
        chk("rnd.pass", 32'(a_pass), 32'(es == gold));
        a_din = 2'($urandom); a_abort = 1;
        tick;
        a_abort = 0;
        a_state("rnd.hold", es, 1'b0, 1'b1, es == gold);
      end
    end

    // default 16-bit configuration
    b_seed_load = 1; b_seed_in = 16'h0001;
    tick;
    b_seed_load = 0; b_start = 1; b_num = 16; b_golden = 16'h002D; b_din = 0;
    tick;
    b_start = 0;
    repeat (16) tick;
    chk("w16.sig", 32'(b_sig), 32'h002D);
    chk("w16.done", 32'(b_done), 32'h1);
    chk("w16.pass", 32'(b_pass), 32'h1);

    // 16-bit run with random 3-bit responses
    bs = 16'($urandom);
    bd = bs;
    for (int k = 0; k < 20; k++) dins[k] = 2'($urandom);
    b_seed_load = 1; b_seed_in = bs; b_start = 1; b_num = 20; b_golden = 16'hFFFF;
    tick;
    b_seed_load = 0; b_start = 0;
    for (int k = 0; k < 20; k++) begin
      b_din = 3'($urandom);
      tick;
      bd = 16'(mstep(16, 32'h002D, 32'(bd), 32'(b_din)));
      chk("w16.rnd_sig", 32'(b_sig), 32'(bd));
    end
    chk("w16.rnd_pass", 32'(b_pass), 32'(bd == 16'hFFFF));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/misr_bist_compactor.md
Name: misr_bist_compactor

Overview:
- Parametrised multiple-input signature register (MISR) with a built-in compaction controller.
- Compacts an NIN-bit response bus into a WIDTH-bit signature over a programmed number of cycles, then compares it against a golden value.
- Provides seed load, abort and pass/fail reporting.
- Sits at the output of a circuit-under-test in the BIST path. Successor to the fixed 15-bit, 3-input compactor.

Parameters:
- WIDTH, 16, signature register width (>= 2).
- NIN, 3, number of parallel response inputs (1 <= NIN <= WIDTH).
- POLY, 16'h002D, feedback tap mask for x^16+x^5+x^3+x^2+1. Bit i set => tap into stage i. Width = WIDTH.
- SEED, 0, signature value after reset.
- CNT_W, 16, width of the cycle-count input.

Ports:
- CLK  in  1  clock, rising-edge.
- RST_N  in  1  synchronous active-low reset.
- start  in  1  begin a compaction run (accepted in IDLE or DONE only).
- abort  in  1  terminate a run in progress.
- seed_load  in  1  load seed_in into signature (IDLE/DONE only).
- seed_in  in  WIDTH  seed value.
- num_cycles  in  CNT_W  number of compaction cycles, sampled on start.
- golden  in  WIDTH  expected signature, sampled on start.
- din  in  NIN  response bits from circuit-under-test.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- pass  out  1  signature == captured golden, valid while done.
- signature  out  WIDTH  current MISR contents.

Behaviour:
- Reset (RST_N=0 at a rising edge) overrides everything:
  - state=IDLE, signature=SEED, busy=0, done=0, pass=0.
  - Counter and golden register cleared.
  - Reset during RUN discards the run.
- Update rule, applied once per RUN cycle:
  - sig_next = {sig[WIDTH-2:0],1'b0} XOR (sig[WIDTH-1] ? POLY : 0) XOR zero-extended din.
  - din[k] enters stage k.
- FSM states: IDLE, RUN, DONE. busy = (state==RUN), done = (state==DONE).
- IDLE/DONE with start=1:
  - golden captured.
  - counter <= num_cycles.
  - signature <= seed_load ? seed_in : signature.
  - done and pass clear.
  - Next state RUN, or DONE if num_cycles==0.
- IDLE/DONE with seed_load=1 and start=0: signature <= seed_in; state unchanged. In DONE, pass is recomputed against the held golden.
- RUN, each cycle without abort:
  - signature <= sig_next using din sampled that edge; counter decrements.
  - On the edge where counter goes 1 -> 0, enter DONE.
  - Exactly num_cycles updates occur; first update on the edge after start.
- Entering DONE: pass <= (final signature == golden), registered and valid the same cycle done rises.
- DONE holds signature, pass and done until start, seed_load or reset.
- RUN with abort=1:
  - Go to IDLE; signature not updated that edge.
  - pass=0, done stays 0.
  - abort is ignored outside RUN.
- In RUN, start and seed_load are ignored. In IDLE/DONE, din is ignored.
- abort has priority over the terminal count in the same cycle.
- Counter arithmetic is unsigned; no wrap (RUN never decrements below 0).
- Latency: start -> done = num_cycles+1 edges (1 edge if num_cycles==0).

Test Plan:
- Config WIDTH=4, NIN=2, POLY=4'h3:
  - Reset -> signature=SEED=0, busy=0, done=0, pass=0.
  - seed_load with seed_in=4'h1, then start with num_cycles=4, din=0 -> signature 2,4,8,3. done=1 after the 4th update; with golden=4'h3, pass=1.
- Seed 0, din=2'b01 constant, num_cycles=3, golden=4'h7 -> signature 1,3,7; pass=1. Repeat with golden=4'h6 -> pass=0.
- Seed 1, din=0, num_cycles=15 -> signature returns to 4'h1 (maximal period); no intermediate zero.
- Abort after 2 updates of a 4-cycle run -> IDLE, done=0, signature frozen at the 2nd value. A following seed_load then start runs normally.
- num_cycles=0 with start -> done next edge, signature unchanged. Also:
  - start+seed_load in the same cycle seeds first.
  - start while busy is ignored.
  - RST_N=0 mid-run -> all outputs reset.
- Default parameters: seed 16'h0001, din=0, 16 cycles -> signature 16'h002D; pass against golden 16'h002D.
